// File: rtl/upsampler_n_pkg.sv
// Shared definitions for the upsampler: default data geometry and output mode encodings.
package upsampler_n_pkg;

  localparam int WIDTH_DEF = 18;
  localparam int NCH_DEF   = 2;

  // Behaviour of the non-symbol slots of each symbol period
  typedef enum logic {
    MODE_ZERO = 1'b0,  // zero-stuff: non-symbol slots output signed zero
    MODE_HOLD = 1'b1   // sample-and-hold: non-symbol slots repeat the last value
  } mode_e;

  localparam int FACTOR_MIN = 2;
  localparam int FACTOR_MAX = 16;

endpackage

// File: rtl/upsampler_slot_ctr.sv
// Slot counter within the symbol period, plus the symbol-alignment monitor
// (armed flag, align_err pulse, saturating error counter).
module upsampler_slot_ctr
  import upsampler_n_pkg::*;
#(
  parameter int FACTOR = 4,
  parameter int ERRW   = 8,
  parameter int CW     = $clog2(FACTOR)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sam_clk_en,
  input  logic            sym_clk_en,
  input  logic            clr_err,
  output logic [CW-1:0]   phase,
  output logic [CW-1:0]   slot,
  output logic            align_err,
  output logic [ERRW-1:0] err_count
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(FACTOR - 1);
  localparam logic [CW-1:0] NEXT_SLOT = CW'(1);

  logic [CW-1:0]   phase_q, phase_d;
  logic            armed_q, armed_d;
  logic            align_err_q, align_err_d;
  logic [ERRW-1:0] err_count_q, err_count_d;
  logic            err_hit;

  // Next-state logic: slot advance, arming and error counting
  always_comb begin
    phase_d = phase_q;
    if (sym_clk_en && sam_clk_en) begin
      // This edge is slot 0 itself, so the counter moves straight on to slot 1
      phase_d = NEXT_SLOT;
    end else if (sym_clk_en) begin
      phase_d = '0;
    end else if (sam_clk_en) begin
      phase_d = (phase_q == LAST_SLOT) ? '0 : phase_q + 1'b1;
    end

    // A symbol strobe coinciding with a sample strobe must land on the wrap
    err_hit     = sym_clk_en && sam_clk_en && armed_q && (phase_q != '0);
    armed_d     = armed_q | sym_clk_en;
    align_err_d = err_hit;

    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = '0;
    end else if (err_hit && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= '0;
      armed_q     <= 1'b0;
      align_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      phase_q     <= phase_d;
      armed_q     <= armed_d;
      align_err_q <= align_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign slot      = sym_clk_en ? '0 : phase_q;
  assign phase     = phase_q;
  assign align_err = align_err_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/upsampler_n.sv
// Zero-stuffing / sample-and-hold interpolator by FACTOR over NCH lock-step channels.
module upsampler_n
  import upsampler_n_pkg::*;
#(
  parameter int FACTOR = 4,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NCH    = NCH_DEF,
  parameter int PHASE  = 0,
  parameter int ERRW   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sam_clk_en,
  input  logic                       sym_clk_en,
  input  logic                       mode,
  input  logic                       clr_err,
  input  logic [NCH*WIDTH-1:0]       data_in,
  output logic [NCH*WIDTH-1:0]       data_out,
  output logic                       out_valid,
  output logic [$clog2(FACTOR)-1:0]  phase,
  output logic                       align_err,
  output logic [ERRW-1:0]            err_count
);

  localparam int CW = $clog2(FACTOR);

  if (FACTOR < FACTOR_MIN || FACTOR > FACTOR_MAX) begin : g_bad_factor
    $fatal(1, "upsampler_n: FACTOR=%0d outside 2..16", FACTOR);
  end
  if (PHASE < 0 || PHASE >= FACTOR) begin : g_bad_phase
    $fatal(1, "upsampler_n: PHASE=%0d must be in 0..FACTOR-1", PHASE);
  end

  localparam logic [CW-1:0] PHASE_SLOT = CW'(PHASE);

  logic [CW-1:0] slot;
  logic          sym_slot;
  logic          zero_fill;
  logic          out_valid_q;

  upsampler_slot_ctr #(
    .FACTOR (FACTOR),
    .ERRW   (ERRW),
    .CW     (CW)
  ) u_slot_ctr (
    .clk        (clk),
    .reset_n    (reset_n),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .clr_err    (clr_err),
    .phase      (phase),
    .slot       (slot),
    .align_err  (align_err),
    .err_count  (err_count)
  );

  assign sym_slot  = (slot == PHASE_SLOT);
  assign zero_fill = (mode_e'(mode) == MODE_ZERO);

  // Per-channel output registers; channels share the slot decision
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [WIDTH-1:0] ch_q, ch_d;

    // Select symbol value, zero or held value for this channel
    always_comb begin
      ch_d = ch_q;
      if (sam_clk_en) begin
        if (sym_slot) begin
          ch_d = data_in[k*WIDTH +: WIDTH];
        end else if (zero_fill) begin
          ch_d = '0;
        end
      end
    end

    // Channel sample register
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ch_q <= '0;
      end else begin
        ch_q <= ch_d;
      end
    end

    assign data_out[k*WIDTH +: WIDTH] = ch_q;
  end

  // Output strobe tracks the sample enable with the same one-clock latency as the data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= sam_clk_en;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_upsampler_n.sv
module tb_upsampler_n;

  localparam int W = 18;
  localparam int N = 2;
  localparam int F = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           sam_clk_en;
  logic           sym_clk_en;
  logic           mode;
  logic           clr_err;
  logic [N*W-1:0] data_in;

  logic [N*W-1:0] data_out,  data_out_p2;
  logic           out_valid, out_valid_p2;
  logic [1:0]     phase,     phase_p2;
  logic           align_err, align_err_p2;
  logic [7:0]     err_count, err_count_p2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  upsampler_n #(.FACTOR(F), .WIDTH(W), .NCH(N), .PHASE(0), .ERRW(8)) dut (
    .clk(clk), .reset_n(reset_n), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .mode(mode), .clr_err(clr_err), .data_in(data_in), .data_out(data_out),
    .out_valid(out_valid), .phase(phase), .align_err(align_err), .err_count(err_count)
  );

  upsampler_n #(.FACTOR(F), .WIDTH(W), .NCH(N), .PHASE(2), .ERRW(8)) dut_p2 (
    .clk(clk), .reset_n(reset_n), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .mode(mode), .clr_err(clr_err), .data_in(data_in), .data_out(data_out_p2),
    .out_valid(out_valid_p2), .phase(phase_p2), .align_err(align_err_p2), .err_count(err_count_p2)
  );

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [N*W-1:0] pack(input logic signed [W-1:0] i, input logic signed [W-1:0] q);
    return {q, i};
  endfunction

  task automatic cyc(input logic sym, input logic sam);
    sym_clk_en = sym;
    sam_clk_en = sam;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sam_clk_en = 1'b0; sym_clk_en = 1'b0; mode = 1'b0; clr_err = 1'b0;
    data_in = pack(18'sd100, -18'sd7);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({data_out, data_out_p2} !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h want=0", data_out, data_out_p2);
    end
    checks++;
    if ({out_valid, phase, align_err, err_count} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got valid=%0b phase=%0d err=%0b cnt=%0d want all 0",
               out_valid, phase, align_err, err_count);
    end
    #3 reset_n = 1'b1;
  endtask

  task automatic test_zero_stuff();
    logic [N*W-1:0] exp;
    mode = 1'b0;
    data_in = pack(18'sd100, -18'sd7);
    for (int s = 0; s < 2*F; s++) begin
      cyc(s % F == 0, 1'b1);
      exp = (s % F == 0) ? pack(18'sd100, -18'sd7) : '0;
      checks++;
      if (data_out !== exp) begin
        failures++;
        $display("FAIL zero_stuff_data s=%0d got I=%0d Q=%0d want I=%0d Q=%0d", s,
                 $signed(data_out[W-1:0]), $signed(data_out[2*W-1:W]),
                 $signed(exp[W-1:0]), $signed(exp[2*W-1:W]));
      end
      checks++;
      if ({out_valid, phase, align_err} !== {1'b1, 2'((s + 1) % F), 1'b0}) begin
        failures++;
        $display("FAIL zero_stuff_ctrl s=%0d got valid=%0b phase=%0d err=%0b want 1 %0d 0",
                 s, out_valid, phase, align_err, (s + 1) % F);
      end
    end
  endtask

  task automatic test_hold();
    logic [N*W-1:0] ext;
    mode = 1'b1;
    data_in = pack(18'sd100, -18'sd7);
    for (int s = 0; s < F; s++) begin
      cyc(s == 0, 1'b1);
      checks++;
      if (data_out !== pack(18'sd100, -18'sd7)) begin
        failures++;
        $display("FAIL hold_data s=%0d got I=%0d Q=%0d want I=100 Q=-7", s,
                 $signed(data_out[W-1:0]), $signed(data_out[2*W-1:W]));
      end
    end
    ext = pack(-18'sd131072, 18'sd131071);
    data_in = ext;
    cyc(1'b1, 1'b1);
    data_in = pack(18'sd5, 18'sd5);
    for (int s = 0; s < F; s++) begin
      checks++;
      if (data_out !== ext) begin
        failures++;
        $display("FAIL hold_extreme s=%0d got=%h want=%h", s, data_out, ext);
      end
      if (s < F - 1) cyc(1'b0, 1'b1);
    end
  endtask

  task automatic test_phase2();
    logic [N*W-1:0] exp;
    mode = 1'b0;
    data_in = pack(18'sd1234, -18'sd55);
    for (int s = 0; s < 2*F; s++) begin
      cyc(s % F == 0, 1'b1);
      exp = (s % F == 2) ? pack(18'sd1234, -18'sd55) : '0;
      checks++;
      if (data_out_p2 !== exp) begin
        failures++;
        $display("FAIL phase2_data s=%0d got I=%0d Q=%0d want I=%0d Q=%0d", s,
                 $signed(data_out_p2[W-1:0]), $signed(data_out_p2[2*W-1:W]),
                 $signed(exp[W-1:0]), $signed(exp[2*W-1:W]));
      end
    end
  endtask

  task automatic test_align();
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    checks++;
    if ({align_err, phase} !== {1'b0, 2'd2}) begin
      failures++; $display("FAIL align_pre got err=%0b phase=%0d want 0 2", align_err, phase);
    end
    cyc(1'b1, 1'b1);
    checks++;
    if ({align_err, err_count, phase} !== {1'b1, 8'd1, 2'd1}) begin
      failures++;
      $display("FAIL align_first got err=%0b cnt=%0d phase=%0d want 1 1 1", align_err, err_count, phase);
    end
    cyc(1'b0, 1'b1);
    checks++;
    if ({align_err, err_count} !== {1'b0, 8'd1}) begin
      failures++; $display("FAIL align_pulse_width got err=%0b cnt=%0d want 0 1", align_err, err_count);
    end
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b1);
      if (i == 299) begin
        checks++;
        if ({align_err, err_count} !== {1'b1, 8'd255}) begin
          failures++; $display("FAIL align_saturate got err=%0b cnt=%0d want 1 255", align_err, err_count);
        end
      end
      cyc(1'b0, 1'b1);
    end
    clr_err = 1'b1;
    cyc(1'b0, 1'b0);
    clr_err = 1'b0;
    checks++;
    if ({err_count, phase} !== {8'd0, 2'd2}) begin
      failures++; $display("FAIL align_clear got cnt=%0d phase=%0d want 0 2", err_count, phase);
    end
    clr_err = 1'b1;
    cyc(1'b1, 1'b1);
    clr_err = 1'b0;
    checks++;
    if ({align_err, err_count} !== {1'b1, 8'd0}) begin
      failures++; $display("FAIL align_clr_coincide got err=%0b cnt=%0d want 1 0", align_err, err_count);
    end
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    checks++;
    if ({align_err, err_count, phase} !== {1'b0, 8'd0, 2'd0}) begin
      failures++;
      $display("FAIL align_silent got err=%0b cnt=%0d phase=%0d want 0 0 0", align_err, err_count, phase);
    end
  endtask

  task automatic test_sparse_enable();
    logic [N*W-1:0] exp;
    logic [1:0]     exp_ph;
    mode = 1'b0;
    data_in = pack(18'sd77, -18'sd3);
    cyc(1'b1, 1'b1);
    exp = pack(18'sd77, -18'sd3);
    exp_ph = 2'd1;
    checks++;
    if ({data_out, out_valid, phase} !== {exp, 1'b1, exp_ph}) begin
      failures++; $display("FAIL sparse_start got=%h v=%0b ph=%0d want=%h 1 1", data_out, out_valid, phase, exp);
    end
    for (int r = 0; r < 4; r++) begin
      for (int g = 0; g < 2; g++) begin
        cyc(1'b0, 1'b0);
        checks++;
        if ({data_out, out_valid, phase} !== {exp, 1'b0, exp_ph}) begin
          failures++;
          $display("FAIL sparse_hold r=%0d got=%h v=%0b ph=%0d want=%h 0 %0d",
                   r, data_out, out_valid, phase, exp, exp_ph);
        end
      end
      cyc(1'b0, 1'b1);
      exp_ph = exp_ph + 2'd1;
      exp = (r == 3) ? pack(18'sd77, -18'sd3) : '0;
      checks++;
      if ({data_out, out_valid, phase} !== {exp, 1'b1, exp_ph}) begin
        failures++;
        $display("FAIL sparse_update r=%0d got=%h v=%0b ph=%0d want=%h 1 %0d",
                 r, data_out, out_valid, phase, exp, exp_ph);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    checks++;
    if ({align_err, err_count} !== {1'b1, 8'd1}) begin
      failures++; $display("FAIL midrst_pre got err=%0b cnt=%0d want 1 1", align_err, err_count);
    end
    data_in = pack(18'sd9, -18'sd9);
    cyc(1'b0, 1'b1);
    sym_clk_en = 1'b0; sam_clk_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({data_out, data_out_p2, out_valid, phase, align_err, err_count} !== '0) begin
      failures++;
      $display("FAIL midrst_async got data=%h v=%0b ph=%0d err=%0b cnt=%0d want all 0",
               data_out, out_valid, phase, align_err, err_count);
    end
    #2 reset_n = 1'b1;
    cyc(1'b0, 1'b1);
    checks++;
    if ({data_out, phase} !== {pack(18'sd9, -18'sd9), 2'd1}) begin
      failures++; $display("FAIL midrst_capture got=%h ph=%0d want=%h 1", data_out, phase, pack(18'sd9, -18'sd9));
    end
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    checks++;
    if ({align_err, err_count, phase} !== {1'b0, 8'd0, 2'd1}) begin
      failures++;
      $display("FAIL midrst_exempt got err=%0b cnt=%0d ph=%0d want 0 0 1", align_err, err_count, phase);
    end
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    checks++;
    if ({align_err, err_count} !== {1'b1, 8'd1}) begin
      failures++; $display("FAIL midrst_rearmed got err=%0b cnt=%0d want 1 1", align_err, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_zero_stuff();
    test_hold();
    test_phase2();
    test_align();
    test_sparse_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
